// File: rtl/mte_frame_checker_if.sv
// Word-stream bundle between the MTE output stage and the frame checker.
// The checker sits on the slave side: it consumes words and drives the frame results.
interface mte_frame_checker_if #(
    parameter int N     = 8,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic [N-1:0]     in_data;
    logic             key_valid;
    logic             out_valid;
    logic [N-1:0]     out_data;
    logic             out_last;
    logic             frame_done;
    logic             mac_ok;
    logic             key_err;
    logic [CNT_W-1:0] frames_ok;
    logic [CNT_W-1:0] frames_bad;

    modport master (
        output in_valid, in_data, key_valid,
        input  out_valid, out_data, out_last, frame_done, mac_ok, key_err,
               frames_ok, frames_bad
    );

    modport slave (
        input  in_valid, in_data, key_valid,
        output out_valid, out_data, out_last, frame_done, mac_ok, key_err,
               frames_ok, frames_bad
    );
endinterface

// File: rtl/mte_frame_checker.sv
// Groups the MTE word stream into FRAME_LEN payload words plus one MAC word,
// forwards the payload, checks a rotate-XOR MAC and keeps saturating frame counters.
module mte_frame_checker #(
    parameter int N         = 8,
    parameter int FRAME_LEN = 4,
    parameter int CNT_W     = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    mte_frame_checker_if.slave   bus
);
    typedef enum logic {
        S_PAYLOAD = 1'b0,
        S_MAC     = 1'b1
    } state_t;

    // FRAME_LEN is limited to 255, so an 8-bit word counter always suffices.
    localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

    state_t           state;
    logic [7:0]       cnt;
    logic [N-1:0]     mac;
    logic [N-1:0]     mac_next;

    logic             out_valid_r;
    logic [N-1:0]     out_data_r;
    logic             out_last_r;
    logic             frame_done_r;
    logic             mac_ok_r;
    logic             key_err_r;
    logic [CNT_W-1:0] frames_ok_r;
    logic [CNT_W-1:0] frames_bad_r;

    assign mac_next = {mac[N-2:0], mac[N-1]} ^ bus.in_data;

    // NOTE: every register here is updated with <= so all of them sample the
    // pre-edge values; a blocking = would let later statements see new values.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= S_PAYLOAD;
            cnt          <= '0;
            mac          <= '0;
            out_valid_r  <= 1'b0;
            out_data_r   <= '0;
            out_last_r   <= 1'b0;
            frame_done_r <= 1'b0;
            mac_ok_r     <= 1'b0;
            key_err_r    <= 1'b0;
            frames_ok_r  <= '0;
            frames_bad_r <= '0;
        end else begin
            // Single-cycle strobes default low; out_data keeps its last word.
            out_valid_r  <= 1'b0;
            out_last_r   <= 1'b0;
            frame_done_r <= 1'b0;
            mac_ok_r     <= 1'b0;
            key_err_r    <= 1'b0;

            if (bus.in_valid) begin
                if (!bus.key_valid) begin
                    key_err_r <= 1'b1;
                    if (frames_bad_r != '1) frames_bad_r <= frames_bad_r + CNT_W'(1);
                    mac   <= '0;
                    cnt   <= '0;
                    state <= S_PAYLOAD;
                end else begin
                    unique case (state)
                        S_PAYLOAD: begin
                            mac         <= mac_next;
                            out_valid_r <= 1'b1;
                            out_data_r  <= bus.in_data;
                            out_last_r  <= (cnt == LAST_IDX);
                            if (cnt == LAST_IDX) state <= S_MAC;
                            else                 cnt   <= cnt + 8'd1;
                        end
                        S_MAC: begin
                            frame_done_r <= 1'b1;
                            mac_ok_r     <= (bus.in_data == mac);
                            if (bus.in_data == mac) begin
                                if (frames_ok_r != '1) frames_ok_r <= frames_ok_r + CNT_W'(1);
                            end else begin
                                if (frames_bad_r != '1) frames_bad_r <= frames_bad_r + CNT_W'(1);
                            end
                            mac   <= '0;
                            cnt   <= '0;
                            state <= S_PAYLOAD;
                        end
                        default: state <= S_PAYLOAD;
                    endcase
                end
            end
        end
    end

    assign bus.out_valid  = out_valid_r;
    assign bus.out_data   = out_data_r;
    assign bus.out_last   = out_last_r;
    assign bus.frame_done = frame_done_r;
    assign bus.mac_ok     = mac_ok_r;
    assign bus.key_err    = key_err_r;
    assign bus.frames_ok  = frames_ok_r;
    assign bus.frames_bad = frames_bad_r;
endmodule

// File: tb/tb_mte_frame_checker.sv
// Bench for mte_frame_checker: directed and random frames against a queue-based model.
// A second instance with CNT_W=4 shares the stimulus to exercise counter saturation.
module tb_mte_frame_checker;
    localparam int N         = 8;
    localparam int FRAME_LEN = 4;

    typedef logic [N-1:0] word_t;

    logic clock;
    logic reset_n;

    mte_frame_checker_if #(.N(N), .CNT_W(16)) bus1 ();
    mte_frame_checker_if #(.N(N), .CNT_W(4))  bus2 ();

    assign bus2.in_valid  = bus1.in_valid;
    assign bus2.in_data   = bus1.in_data;
    assign bus2.key_valid = bus1.key_valid;

    mte_frame_checker #(.N(N), .FRAME_LEN(FRAME_LEN), .CNT_W(16)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus1.slave)
    );

    mte_frame_checker #(.N(N), .FRAME_LEN(FRAME_LEN), .CNT_W(4)) dut_small (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus2.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state: accepted payload of the frame in progress plus expected outputs.
    word_t frame_q[$];
    logic  e_ov, e_last, e_fd, e_ok, e_ke;
    word_t e_od;
    int    ok_cnt, bad_cnt;

    function automatic word_t rotl1(input word_t x);
        int v;
        v = int'(x);
        return word_t'(((v * 2) % 256) + (v / 128));
    endfunction

    function automatic word_t calc_mac(input word_t words[$]);
        word_t m;
        m = '0;
        foreach (words[i]) m = rotl1(m) ^ words[i];
        return m;
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out_valid"},  32'(bus1.out_valid),  32'(e_ov));
        check({tag, ".out_data"},   32'(bus1.out_data),   32'(e_od));
        check({tag, ".out_last"},   32'(bus1.out_last),   32'(e_last));
        check({tag, ".frame_done"}, 32'(bus1.frame_done), 32'(e_fd));
        check({tag, ".mac_ok"},     32'(bus1.mac_ok),     32'(e_ok));
        check({tag, ".key_err"},    32'(bus1.key_err),    32'(e_ke));
        check({tag, ".frames_ok"},  32'(bus1.frames_ok),  32'(sat(ok_cnt, 65535)));
        check({tag, ".frames_bad"}, 32'(bus1.frames_bad), 32'(sat(bad_cnt, 65535)));
        check({tag, ".ok4"},        32'(bus2.frames_ok),  32'(sat(ok_cnt, 15)));
        check({tag, ".bad4"},       32'(bus2.frames_bad), 32'(sat(bad_cnt, 15)));
    endtask

    // One clock cycle: drive at the falling edge, predict, check just after the rising edge.
    task automatic step(input string tag, input logic iv, input word_t d, input logic kv);
        @(negedge clock);
        reset_n        = 1'b1;
        bus1.in_valid  = iv;
        bus1.in_data   = d;
        bus1.key_valid = kv;
        e_ov = 1'b0; e_last = 1'b0; e_fd = 1'b0; e_ok = 1'b0; e_ke = 1'b0;
        if (iv) begin
            if (!kv) begin
                e_ke = 1'b1;
                bad_cnt++;
                frame_q.delete();
            end else if (frame_q.size() < FRAME_LEN) begin
                frame_q.push_back(d);
                e_ov   = 1'b1;
                e_od   = d;
                e_last = (frame_q.size() == FRAME_LEN);
            end else begin
                e_fd = 1'b1;
                e_ok = (d == calc_mac(frame_q));
                if (e_ok) ok_cnt++;
                else      bad_cnt++;
                frame_q.delete();
            end
        end
        @(posedge clock);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) step(tag, 1'b0, word_t'($urandom), 1'($urandom));
    endtask

    task automatic do_reset(input string tag);
        @(negedge clock);
        reset_n        = 1'b0;
        bus1.in_valid  = 1'b1;
        bus1.in_data   = word_t'($urandom);
        bus1.key_valid = 1'b1;
        frame_q.delete();
        e_ov = 1'b0; e_od = '0; e_last = 1'b0; e_fd = 1'b0; e_ok = 1'b0; e_ke = 1'b0;
        ok_cnt = 0; bad_cnt = 0;
        @(posedge clock);
        #1;
        check_all(tag);
        @(negedge clock);
        reset_n       = 1'b1;
        bus1.in_valid = 1'b0;
    endtask

    // Sends payload then mac_w; gap_pct is the chance of idle cycles before each word.
    task automatic send_frame(input string tag, input word_t words[$], input word_t mac_w,
                              input int gap_pct);
        foreach (words[i]) begin
            if ($urandom_range(99) < gap_pct) idle({tag, ".gap"}, $urandom_range(1, 3));
            step(tag, 1'b1, words[i], 1'b1);
        end
        if ($urandom_range(99) < gap_pct) idle({tag, ".gap"}, $urandom_range(1, 3));
        step({tag, ".mac"}, 1'b1, mac_w, 1'b1);
    endtask

    initial begin
        word_t frame_a[$];
        word_t frame_ff[$];
        word_t rnd[$];
        frame_a  = '{8'h01, 8'h02, 8'h03, 8'h04};
        frame_ff = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};

        reset_n = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.key_valid = 1'b0;
        do_reset("reset0");
        do_reset("reset1");

        send_frame("frame_a", frame_a, 8'h02, 0);
        idle("idle", 2);
        send_frame("ff_ok", frame_ff, 8'h00, 0);
        send_frame("ff_bad", frame_ff, 8'h01, 0);

        step("abort.w0", 1'b1, 8'h01, 1'b1);
        step("abort.w1", 1'b1, 8'h02, 1'b1);
        step("abort.w2", 1'b1, 8'h03, 1'b0);
        send_frame("after_abort", frame_a, 8'h02, 0);

        send_frame("b2b_0", frame_a, 8'h02, 0);
        send_frame("b2b_1", frame_a, 8'h02, 0);

        for (int f = 0; f < 8; f++) begin
            rnd.delete();
            for (int i = 0; i < FRAME_LEN; i++) rnd.push_back(word_t'($urandom));
            send_frame("rand_gap", rnd, calc_mac(rnd), 40);
        end

        for (int f = 0; f < 4; f++) begin
            rnd.delete();
            for (int i = 0; i < FRAME_LEN; i++) rnd.push_back(word_t'($urandom));
            send_frame("rand_bad", rnd, calc_mac(rnd) ^ word_t'($urandom_range(1, 255)), 20);
        end

        for (int i = 0; i < FRAME_LEN; i++) step("kill_mac.p", 1'b1, frame_a[i], 1'b1);
        step("kill_mac.m", 1'b1, 8'h02, 1'b0);

        for (int i = 0; i < 60; i++)
            step("rand_stream", 1'($urandom_range(3) != 0), word_t'($urandom),
                 1'($urandom_range(9) != 0));
        idle("drain", 1);
        for (int i = 0; i < int'(frame_q.size()); i++) step("flush", 1'b1, 8'h00, 1'b0);

        step("part.w0", 1'b1, 8'h01, 1'b1);
        step("part.w1", 1'b1, 8'h02, 1'b1);
        do_reset("mid_reset");
        send_frame("post_reset", frame_a, 8'h02, 0);

        do_reset("reset_sat");
        for (int f = 0; f < 17; f++) send_frame("sat", frame_ff, 8'h5A, 0);
        check("sat.bad4_final", 32'(bus2.frames_bad), 32'd15);
        check("sat.bad16_final", 32'(bus1.frames_bad), 32'd17);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
